// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, default widths and output-width helper for fir_tdm_mac
package fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  localparam int DEF_DW = 4;
  localparam int DEF_CW = 3;
  localparam int DEF_TAPS = 4;
  function automatic int fir_ow(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: TAPS x CW coefficient registers, writable only while idle, read by tap index
module fir_coef_bank import fir_pkg::*; #(
  parameter int CW = DEF_CW,
  parameter int TAPS = DEF_TAPS,
  localparam int AW = $clog2(TAPS)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          idle,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [CW-1:0] data,
  input  logic [AW-1:0] k,
  output logic [CW-1:0] coef_k
);
  logic [CW-1:0] coef [TAPS];
  assign coef_k = coef[k];
  // clear on reset; writes land only in IDLE and only for in-range addresses
  always_ff @(posedge CLK) begin
    if (reset)
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    else if (we && idle && {1'b0, addr} < (AW+1)'(TAPS))
      coef[addr] <= data;
  end
endmodule

// File: rtl/fir_tdm_mac.sv
// fir_tdm_mac: TAPS-tap FIR sharing one MAC per sample; define FIR_SIGNED_EN for two's-complement arithmetic
module fir_tdm_mac import fir_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW,
  parameter int TAPS = DEF_TAPS,
  localparam int AW = $clog2(TAPS),
  localparam int OW = fir_ow(DW, CW, TAPS)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          busy
);
  state_t state, state_nx;
  logic [DW-1:0] x [TAPS];
  logic [AW-1:0] k;
  logic [CW-1:0] coef_k;
  logic [OW-1:0] acc, prod, cx, xx;
  logic last;
  assign last = k == AW'(TAPS - 1);
  assign in_ready = state == IDLE && !reset;
  assign out_valid = state == OUT;
  assign busy = state != IDLE;
`ifdef FIR_SIGNED_EN
  assign cx = {{(OW-CW){coef_k[CW-1]}}, coef_k};
  assign xx = {{(OW-DW){x[k][DW-1]}}, x[k]};
`else
  assign cx = {{(OW-CW){1'b0}}, coef_k};
  assign xx = {{(OW-DW){1'b0}}, x[k]};
`endif
  assign prod = cx * xx;
  fir_coef_bank #(.CW(CW), .TAPS(TAPS)) u_bank (
    .CLK(CLK),
    .reset(reset),
    .idle(state == IDLE),
    .we(coef_we),
    .addr(coef_addr),
    .data(coef_data),
    .k(k),
    .coef_k(coef_k)
  );
  // state register
  always_ff @(posedge CLK) state <= reset ? IDLE : state_nx;
  // IDLE -> MAC on a sample, MAC -> OUT after the last tap, OUT -> IDLE once consumed
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && in_valid) ? MAC :
               (state == MAC && last) ? OUT :
               (state == OUT && out_ready) ? IDLE : state;
  end
  // delay line shift on accept, one tap accumulated per MAC cycle, result latched on the last tap
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      acc <= '0;
      k <= '0;
      out_data <= '0;
    end else if (state == IDLE && in_valid) begin
      for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
      x[0] <= in_data;
      acc <= '0;
      k <= '0;
    end else if (state == MAC) begin
      acc <= acc + prod;
      k <= last ? '0 : k + 1'b1;
      if (last) out_data <= acc + prod;
    end
  end
endmodule
